// File: rtl/npu_pkg.sv
// Shared widths, int8 limits and the requantisation helpers.
// sat_acc clamps the bias sum; round_shift_sat rounds, applies ReLU and clamps.
package npu_pkg;

    localparam int ACC_W   = 32;
    localparam int MULT_W  = 16;
    localparam int SHIFT_W = 5;
    localparam int OUT_W   = 8;
    localparam int CNT_W   = 16;
    localparam int PROD_W  = ACC_W + MULT_W + 1;
    localparam int R_W     = PROD_W + 1;

    localparam logic signed [OUT_W-1:0] INT8_MAX = OUT_W'(127);
    localparam logic signed [OUT_W-1:0] INT8_MIN = OUT_W'(-128);

    localparam logic signed [R_W-1:0] R_MAX = R_W'(127);
    localparam logic signed [R_W-1:0] R_MIN = R_W'(-128);

    typedef struct packed {
        logic signed [OUT_W-1:0] val;
        logic                    sat;
    } rq_res_t;

    // Overflow of the ACC_W+1 bit sum shows up as the top two bits differing.
    function automatic logic signed [ACC_W-1:0] sat_acc(
        input logic signed [ACC_W:0] s
    );
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_acc = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                               : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_acc = s[ACC_W-1:0];
        end
    endfunction

    // One guard bit above the product keeps the rounding add from overflowing.
    function automatic rq_res_t round_shift_sat(
        input logic signed [PROD_W-1:0] p,
        input logic        [SHIFT_W-1:0] sh,
        input logic                      relu
    );
        logic signed [R_W-1:0] r;
        logic signed [R_W-1:0] half;
        rq_res_t               res;
        r    = {p[PROD_W-1], p};
        half = '0;
        if (sh != '0) begin
            half = R_W'(1) << (sh - SHIFT_W'(1));
            r    = (r + half) >>> sh;
        end
        if (relu && r[R_W-1]) begin
            r = '0;
        end
        res.sat = 1'b0;
        res.val = r[OUT_W-1:0];
        if (r > R_MAX) begin
            res.val = INT8_MAX;
            res.sat = 1'b1;
        end else if (r < R_MIN) begin
            res.val = INT8_MIN;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/npu_requant.sv
// Requantisation output stage: bias add, fixed-point scale, round-shift,
// ReLU and int8 saturation in a 3-stage pipe with whole-pipe stall.
// Ports: clk/rst, in_valid/in_ready + acc_in/bias/mult/shift/relu_en,
// out_valid/out_ready + out_data, busy, sat_cnt (saturated output beats).
module npu_requant
    import npu_pkg::*;
#(
    parameter int ACC_W   = npu_pkg::ACC_W,
    parameter int MULT_W  = npu_pkg::MULT_W,
    parameter int SHIFT_W = npu_pkg::SHIFT_W,
    parameter int OUT_W   = npu_pkg::OUT_W,
    parameter int CNT_W   = npu_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   acc_in,
    input  logic [ACC_W-1:0]   bias,
    input  logic [MULT_W-1:0]  mult,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               busy,
    output logic [CNT_W-1:0]   sat_cnt
);

    localparam int P_W = ACC_W + MULT_W + 1;

    logic                    v1_q, v2_q, v3_q;
    logic signed [ACC_W-1:0] s1_q, s1_d;
    logic signed [P_W-1:0]   p_q, p_d;
    logic signed [OUT_W-1:0] out_q;
    logic                    sat3_q;
    logic [CNT_W-1:0]        sat_cnt_q;
    logic signed [ACC_W:0]   sum;
    rq_res_t                 res;
    logic                    adv;

    // Every stage moves together; a full last stage blocks the whole pipe.
    assign adv      = !v3_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        sum  = {acc_in[ACC_W-1], acc_in} + {bias[ACC_W-1], bias};
        s1_d = sat_acc(sum);
        p_d  = P_W'(s1_q) * P_W'($signed({1'b0, mult}));
        res  = round_shift_sat(p_q, shift, relu_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            s1_q      <= '0;
            p_q       <= '0;
            out_q     <= '0;
            sat3_q    <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            if (adv) begin
                v1_q   <= in_valid;
                v2_q   <= v1_q;
                v3_q   <= v2_q;
                s1_q   <= s1_d;
                p_q    <= p_d;
                out_q  <= res.val;
                sat3_q <= res.sat;
            end
            // Counter sticks at all-ones instead of wrapping.
            if (v3_q && out_ready && sat3_q && sat_cnt_q != '1) begin
                sat_cnt_q <= sat_cnt_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = v3_q;
    assign out_data  = out_q;
    assign busy      = v1_q | v2_q | v3_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_npu_requant.sv
// Scoreboard bench for npu_requant: directed beats push expected int8
// results; a monitor pops and compares on every output handshake.
module tb_npu_requant;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       acc_in;
    logic [31:0]       bias;
    logic [15:0]       mult;
    logic [4:0]        shift;
    logic              relu_en;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              busy;
    logic [15:0]       sat_cnt;

    always #5 clk = ~clk;

    npu_requant dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .acc_in   (acc_in),
        .bias     (bias),
        .mult     (mult),
        .shift    (shift),
        .relu_en  (relu_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .sat_cnt  (sat_cnt)
    );

    int                checks   = 0;
    int                errors   = 0;
    int                accepted = 0;
    int                popped   = 0;
    int                exp_sat  = 0;
    bit                burst_done;
    logic signed [7:0] expq[$];
    logic signed [7:0] mon_e;

    task automatic check(input string name, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change on negedges; the monitor looks 2 time units later,
    // so it sees exactly the values present at the next rising edge.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_data: unexpected beat %0d, none queued",
                         out_data);
            end else begin
                mon_e = expq.pop_front();
                check("out_data", out_data, mon_e);
                popped++;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] m, input logic [4:0] s,
                        input logic r, input logic signed [7:0] e,
                        input bit sat);
        bit done;
        done = 0;
        @(negedge clk);
        acc_in   = a;
        bias     = b;
        mult     = m;
        shift    = s;
        relu_en  = r;
        in_valid = 1'b1;
        #1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready) begin
                expq.push_back(e);
                if (sat) exp_sat++;
                accepted++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done = 1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        if (!done) begin
            in_valid = 1'b0;
            check("send_timeout", 0, 1);
        end
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            #3;
            if (!busy && expq.size() == 0) ok = 1;
        end
        if (!ok) check(name, 0, 1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        acc_in    = '0;
        bias      = '0;
        mult      = 16'd1;
        shift     = '0;
        relu_en   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);

        // Pass-through and latency: valid appears on the third edge
        // counting the acceptance edge (one edge per stage).
        send(32'd26, 32'd0, 16'd1, 5'd0, 1'b0, 8'sd26, 0);
        check("lat_edge1", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge2", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge3", out_valid, 1);
        check("lat_data", out_data, 26);
        drain("drain_t1");
        check("t1_sat_cnt", sat_cnt, 0);

        // (26+4)*3 = 90, (90+2)>>>2 = 23
        send(32'd26, 32'd4, 16'd3, 5'd2, 1'b0, 8'sd23, 0);
        drain("drain_t2a");
        // (-5+1)>>>1 = -2
        send(-32'sd5, 32'd0, 16'd1, 5'd1, 1'b0, -8'sd2, 0);
        drain("drain_t2b");

        send(-32'sd100, 32'd0, 16'd1, 5'd0, 1'b0, -8'sd100, 0);
        drain("drain_t3a");
        send(-32'sd100, 32'd0, 16'd1, 5'd0, 1'b1, 8'sd0, 0);
        drain("drain_t3b");
        check("t3_sat_cnt", sat_cnt, 0);

        send(32'd1000, 32'd0, 16'd1, 5'd0, 1'b0, 8'sd127, 1);
        send(-32'sd1000, 32'd0, 16'd1, 5'd0, 1'b0, -8'sd128, 1);
        drain("drain_t4");
        check("t4_sat_cnt", sat_cnt, 2);

        // S1 clamps to 0x7FFFFFFF; rounding >>24 gives 128 -> 127
        send(32'h7FFF_FFF0, 32'h100, 16'd1, 5'd24, 1'b0, 8'sd127, 1);
        drain("drain_t5");
        check("t5_sat_cnt", sat_cnt, exp_sat);

        // Backpressure: three beats fill the pipe, then it stalls.
        @(negedge clk);
        out_ready  = 1'b0;
        accepted   = 0;
        burst_done = 0;
        popped     = 0;
        fork
            begin
                for (int k = 1; k <= 5; k++) begin
                    send(k, 32'd0, 16'd1, 5'd0, 1'b0, 8'(k), 0);
                end
                burst_done = 1;
            end
        join_none
        repeat (6) @(negedge clk);
        #3;
        check("stall_accepted", accepted, 3);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", out_data, 1);
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 100 && !(burst_done && expq.size() == 0
                                     && !busy); i++) begin
            @(negedge clk);
            #3;
        end
        check("burst_done", burst_done, 1);
        check("burst_popped", popped, 5);

        // Reset mid-stream drops everything in flight.
        @(negedge clk);
        out_ready = 1'b0;
        send(32'd11, 32'd0, 16'd1, 5'd0, 1'b0, 8'sd11, 0);
        send(32'd12, 32'd0, 16'd1, 5'd0, 1'b0, 8'sd12, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sat_cnt", sat_cnt, 0);
        rst = 1'b0;
        expq.delete();
        exp_sat   = 0;
        out_ready = 1'b1;
        send(32'd7, 32'd0, 16'd1, 5'd0, 1'b0, 8'sd7, 0);
        drain("drain_post_rst");
        check("post_rst_sat_cnt", sat_cnt, exp_sat);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
